jtgng_rom_arb: RTL and testbench

SDRAM ROM-read arbiter between the game video/CPU fetch units and the single jtframe SDRAM read port (`sdram_req`/`sdram_addr`/`sdram_ack`/`data_rdy`/`data_read`). It grants one requester at a time and sequences the request/ack/ready handshake. It keeps a one-entry last-read cache per requester, so repeated fetches of the same 32-bit word complete without an SDRAM cycle. It asserts `refresh_en` whenever the port is idle, and it flushes itself during ROM download or `loop_rst`.

---
 rtl/jtgng_rom_arb.sv | 145 ++++++++++++++
 tb/tb_jtgng_rom_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_rom_arb.sv
// SDRAM ROM-read arbiter with a one-word last-read cache per requester.
// Define JTGNG_ROMARB_RR_EN for round-robin arbitration (fixed priority otherwise).
`timescale 1ns/1ps
module jtgng_rom_arb #(
    parameter int NREQ = 4,
    parameter int AW   = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic              loop_rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]   ok,
    output logic [31:0]       dout,
    output logic              sdram_req,
    output logic [AW-1:0]     sdram_addr,
    input  logic              sdram_ack,
    input  logic              data_rdy,
    input  logic [31:0]       data_read,
    output logic              refresh_en
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, win;
    logic            win_vld, hit, flush, fill;
    logic [AW-1:0]   win_addr;
    logic [NREQ-1:0] valid;
    logic [AW-1:0]   tag   [NREQ];
    logic [31:0]     cache [NREQ];

    assign flush = downloading | loop_rst;
    // Ack and ready in the same cycle complete the read straight from WAIT_ACK
    assign fill  = !flush && data_rdy &&
                   (state == WAIT_RDY || (state == WAIT_ACK && sdram_ack));

`ifdef JTGNG_ROMARB_RR_EN
    logic [GW-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (!flush && state == IDLE && win_vld)
            ptr <= (int'(win) == NREQ-1) ? '0 : win + 1'b1;
    end

    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = GW'(idx);
            end
        end
    end
`else
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (req[k]) begin
                win_vld = 1'b1;
                win     = GW'(k);
            end
        end
    end
`endif

    assign win_addr = req_addr[int'(win)*AW +: AW];
    assign hit      = win_vld && valid[win] && (tag[win] == win_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (win_vld && !hit) state_nxt = WAIT_ACK;
                WAIT_ACK: begin
                    if (fill)           state_nxt = IDLE;
                    else if (sdram_ack) state_nxt = WAIT_RDY;
                end
                WAIT_RDY: if (data_rdy) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok         <= '0;
            dout       <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            refresh_en <= 1'b1;
            valid      <= '0;
            grant      <= '0;
        end else begin
            ok         <= '0;
            refresh_en <= flush || (state == IDLE && !(|req));
            if (flush) begin
                sdram_req <= 1'b0;
                valid     <= '0;
            end else begin
                if (state == IDLE && win_vld) begin
                    if (hit) begin
                        ok[win] <= 1'b1;
                        dout    <= cache[win];
                    end else begin
                        sdram_req  <= 1'b1;
                        sdram_addr <= win_addr;
                        grant      <= win;
                    end
                end
                if (state == WAIT_ACK && sdram_ack) sdram_req <= 1'b0;
                // A requester that gave up still gets its cache line, just no ok
                if (fill) begin
                    ok[grant]    <= req[grant];
                    dout         <= data_read;
                    valid[grant] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            cache[grant] <= data_read;
            tag[grant]   <= sdram_addr;
        end
    end
endmodule

// File: tb/tb_jtgng_rom_arb.sv
// Bench for jtgng_rom_arb: directed vector table, corner sequences, and
// randomized traffic checked against a per-requester last-read model.
`timescale 1ns/1ps
module tb_jtgng_rom_arb;
    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             downloading = 1'b0;
    logic             loop_rst = 1'b0;
    logic [3:0]       req = '0;
    logic [3:0][21:0] addr_arr = '0;
    logic [3:0]       ok;
    logic [31:0]      dout;
    logic             sdram_req;
    logic [21:0]      sdram_addr;
    logic             sdram_ack = 1'b0;
    logic             data_rdy = 1'b0;
    logic [31:0]      data_read = '0;
    logic             refresh_en;

    int errors = 0;
    int checks = 0;

    jtgng_rom_arb #(.NREQ(4), .AW(22)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
        .req(req), .req_addr(addr_arr), .ok(ok), .dout(dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en)
    );

    always #5 clk = ~clk;

    // Reference state: last word read by each requester, and arbitration pointer
    logic        m_valid [4];
    logic [21:0] m_tag   [4];
    logic [31:0] m_data  [4];
    int          m_ptr = 0;

    typedef struct {
        logic [3:0]  req;
        logic [21:0] addr;
        logic [31:0] data;
        int          ack_w;
        int          rdy_w;
        bit          both;
        bit          miss;
        logic [3:0]  exp_ok;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [21:0] a);
        return {a[9:0], a} ^ 32'h9e3779b9;
    endfunction

    function automatic int pick(input logic [3:0] p);
`ifdef JTGNG_ROMARB_RR_EN
        for (int k = 0; k < 4; k++)
            if (p[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`else
        for (int i = 0; i < 4; i++)
            if (p[i]) return i;
`endif
        return 0;
    endfunction

    // req/addr_arr are already driven; the next edge grants the expected requester
    task automatic run_txn(input logic [3:0] exp_ok, input bit miss, input logic [21:0] a,
                           input logic [31:0] data, input int ack_w, input int rdy_w,
                           input bit both, input logic [31:0] exp_dout);
        int w;
        w = 0;
        for (int i = 0; i < 4; i++) if (exp_ok[i]) w = i;
        m_ptr = (w + 1) % 4;
        step();
        chk("refresh_busy", refresh_en, 1'b0);
        if (!miss) begin
            chk("hit_ok", ok, exp_ok);
            chk("hit_dout", dout, exp_dout);
            chk("hit_no_sdram", sdram_req, 1'b0);
        end else begin
            chk("miss_sdram_req", sdram_req, 1'b1);
            chk("miss_addr", sdram_addr, a);
            chk("miss_no_ok", ok, 4'b0);
            for (int i = 0; i < ack_w; i++) begin
                step();
                chk("req_held", sdram_req, 1'b1);
            end
            sdram_ack = 1'b1;
            if (both) begin
                data_rdy  = 1'b1;
                data_read = data;
            end
            step();
            sdram_ack = 1'b0;
            data_rdy  = 1'b0;
            if (!both) begin
                chk("req_drop_on_ack", sdram_req, 1'b0);
                chk("no_ok_before_rdy", ok, 4'b0);
                for (int i = 0; i < rdy_w; i++) step();
                data_rdy  = 1'b1;
                data_read = data;
                step();
                data_rdy  = 1'b0;
            end
            chk("miss_ok", ok, exp_ok);
            chk("miss_dout", dout, exp_dout);
            chk("miss_req_low", sdram_req, 1'b0);
        end
        req = req & ~exp_ok;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  pend;
        logic [21:0] a;
        int          w;
        bit          miss;

        vecs[0] = '{4'b0010, 22'h012345, 32'hDEADBEEF, 2, 1, 1'b0, 1'b1, 4'b0010, 32'hDEADBEEF};
        vecs[1] = '{4'b0010, 22'h012345, 32'h0,        0, 0, 1'b0, 1'b0, 4'b0010, 32'hDEADBEEF};
        vecs[2] = '{4'b0001, 22'h000100, 32'h11112222, 0, 0, 1'b1, 1'b1, 4'b0001, 32'h11112222};
        vecs[3] = '{4'b1000, 22'h3FFFFF, 32'hA5A5A5A5, 1, 0, 1'b0, 1'b1, 4'b1000, 32'hA5A5A5A5};
        vecs[4] = '{4'b1000, 22'h3FFFFE, 32'h01020304, 0, 2, 1'b0, 1'b1, 4'b1000, 32'h01020304};
        vecs[5] = '{4'b1000, 22'h3FFFFE, 32'h0,        0, 0, 1'b0, 1'b0, 4'b1000, 32'h01020304};
        vecs[6] = '{4'b0010, 22'h012345, 32'h0,        0, 0, 1'b0, 1'b0, 4'b0010, 32'hDEADBEEF};
        vecs[7] = '{4'b0100, 22'h012345, 32'hCAFEF00D, 3, 3, 1'b0, 1'b1, 4'b0100, 32'hCAFEF00D};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ok", ok, 4'b0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_sdram_req", sdram_req, 1'b0);
        chk("rst_sdram_addr", sdram_addr, 22'h0);
        chk("rst_refresh", refresh_en, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 4; i++) if (vecs[v].req[i]) addr_arr[i] = vecs[v].addr;
            req = vecs[v].req;
            run_txn(vecs[v].exp_ok, vecs[v].miss, vecs[v].addr, vecs[v].data,
                    vecs[v].ack_w, vecs[v].rdy_w, vecs[v].both, vecs[v].exp_dout);
            step();
            chk("idle_ok_clear", ok, 4'b0);
            chk("idle_refresh", refresh_en, 1'b1);
            chk("idle_no_req", sdram_req, 1'b0);
        end

        // Hit on requester 1 leaves the round-robin pointer at 2
        addr_arr[1] = 22'h012345;
        req = 4'b0010;
        run_txn(4'b0010, 1'b0, 22'h012345, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF);
        step();

        addr_arr[1] = 22'h000100;
        addr_arr[3] = 22'h000300;
        req = 4'b1010;
`ifdef JTGNG_ROMARB_RR_EN
        run_txn(4'b1000, 1'b1, 22'h000300, 32'h33333333, 1, 1, 1'b0, 32'h33333333);
        run_txn(4'b0010, 1'b1, 22'h000100, 32'h11111111, 0, 1, 1'b0, 32'h11111111);
`else
        run_txn(4'b0010, 1'b1, 22'h000100, 32'h11111111, 1, 1, 1'b0, 32'h11111111);
        run_txn(4'b1000, 1'b1, 22'h000300, 32'h33333333, 0, 1, 1'b0, 32'h33333333);
`endif
        step();
        chk("contention_idle", refresh_en, 1'b1);

        // Requester abandons its miss: line still fills, no ok
        addr_arr[2] = 22'h0002A0;
        req = 4'b0100;
        step();
        m_ptr = 3;
        chk("abandon_sdram_req", sdram_req, 1'b1);
        req = 4'b0000;
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        data_rdy  = 1'b1;
        data_read = 32'h13572468;
        step();
        data_rdy = 1'b0;
        chk("abandon_no_ok", ok, 4'b0);
        req = 4'b0100;
        run_txn(4'b0100, 1'b0, 22'h0002A0, 32'h0, 0, 0, 1'b0, 32'h13572468);
        step();

        // Flush while waiting for data
        addr_arr[0] = 22'h000055;
        req = 4'b0001;
        step();
        m_ptr = 1;
        chk("flush_pre_req", sdram_req, 1'b1);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        loop_rst = 1'b1;
        req = 4'b0000;
        step();
        loop_rst = 1'b0;
        chk("flush_sdram_req", sdram_req, 1'b0);
        data_rdy  = 1'b1;
        data_read = 32'h77777777;
        step();
        data_rdy = 1'b0;
        chk("flush_no_ok", ok, 4'b0);
        chk("flush_no_req", sdram_req, 1'b0);
        addr_arr[1] = 22'h012345;
        req = 4'b0010;
        run_txn(4'b0010, 1'b1, 22'h012345, 32'hDEADBEEF, 0, 0, 1'b0, 32'hDEADBEEF);
        step();
        downloading = 1'b1;
        step();
        downloading = 1'b0;
        step();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;

        for (int r = 0; r < 30; r++) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) addr_arr[i] = 22'h3FFFFF;
                else                           addr_arr[i] = 22'($urandom_range(0, 5));
            end
            req = pend;
            while (pend != 4'b0) begin
                w    = pick(pend);
                a    = addr_arr[w];
                miss = !(m_valid[w] && m_tag[w] == a);
                run_txn(4'(1 << w), miss, a, mem(a), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3) == 0, miss ? mem(a) : m_data[w]);
                if (miss) m_data[w] = mem(a);
                m_valid[w] = 1'b1;
                m_tag[w]   = a;
                pend[w]    = 1'b0;
            end
            step();
            chk("rand_idle_refresh", refresh_en, 1'b1);
        end

        // Asynchronous reset in the middle of WAIT_ACK
        addr_arr[2] = 22'h000777;
        req = 4'b0100;
        step();
        chk("areset_pre_req", sdram_req, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_sdram_req", sdram_req, 1'b0);
        chk("areset_refresh", refresh_en, 1'b1);
        chk("areset_ok", ok, 4'b0);
        req = 4'b0000;
        step();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
